k2red_arb: RTL and testbench

K2RED_ARB -- requirements
Module: k2red_arb

---
 rtl/kyber_pkg.sv | 19 +
 rtl/k2red_arb_if.sv | 34 +++
 rtl/k2red.sv | 33 +++
 rtl/k2red_arb.sv | 161 ++++++++++++++++
 tb/tb_k2red_arb.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// kyber_pkg: constants and types shared by the k2red arbiter slice.
//   KQ  - Kyber modulus q = 13 * 2^8 + 1
//   K2  - k^2 for k = 13, the scale applied by K-RED-2
//   C_W - width of an unreduced operand
//   R_W - width of a reduced result
//   id_t, ID_A, ID_B - result source tag
package kyber_pkg;

    localparam int unsigned KQ  = 3329;
    localparam int unsigned K2  = 169;
    localparam int unsigned C_W = 24;
    localparam int unsigned R_W = 12;

    typedef logic id_t;

    localparam id_t ID_A = 1'b0;
    localparam id_t ID_B = 1'b1;

endpackage

// File: rtl/k2red_arb_if.sv
// k2red_arb_if: handshake bundle between two operand requesters, the arbiter
// and a downstream result consumer.
//   a_vld/a_rdy/a_c  requester A operand handshake (c is 24-bit unreduced)
//   b_vld/b_rdy/b_c  requester B operand handshake
//   o_vld/o_rdy      result handshake
//   o_cred, o_id     reduced result and its source (0 = A, 1 = B)
//   busy             any pipeline stage holds data
// Modports: slave = the arbiter, master = the environment around it.
interface k2red_arb_if;
    import kyber_pkg::*;

    logic           a_vld;
    logic           a_rdy;
    logic [C_W-1:0] a_c;
    logic           b_vld;
    logic           b_rdy;
    logic [C_W-1:0] b_c;
    logic           o_vld;
    logic           o_rdy;
    logic [R_W-1:0] o_cred;
    id_t            o_id;
    logic           busy;

    modport slave (
        input  a_vld, a_c, b_vld, b_c, o_rdy,
        output a_rdy, b_rdy, o_vld, o_cred, o_id, busy
    );

    modport master (
        output a_vld, a_c, b_vld, b_c, o_rdy,
        input  a_rdy, b_rdy, o_vld, o_cred, o_id, busy
    );

endinterface

// File: rtl/k2red.sv
// k2red: combinational K-RED-2 reduction, cred = (169 * c) mod 3329.
//   c    input  24  unreduced operand, any value
//   cred output 12  fully reduced result in 0..3328
// Since 13 * 2^8 == -1 (mod q), splitting c into bytes c0, c1, c2 gives
// 169*c == 169*c0 - 13*c1 + c2 (mod q). A Barrett step then finishes the
// reduction of the small intermediate.
module k2red
    import kyber_pkg::*;
(
    input  logic [C_W-1:0] c,
    output logic [R_W-1:0] cred
);

    // floor(2^24 / q); quotient estimate is at most one short for inputs < 2^16
    localparam logic [31:0] BAR_M = 32'd5039;

    logic [15:0] p0;
    logic [15:0] p1;
    logic [15:0] sum;
    logic [3:0]  qest;
    logic [15:0] rem;

    always_comb begin
        p0   = 16'(c[7:0]) * 16'(K2);
        p1   = 16'(c[15:8]) * 16'd13;
        // +q keeps the sum non-negative: range 14..46679
        sum  = p0 + 16'(c[23:16]) + 16'(KQ) - p1;
        qest = 4'((32'(sum) * BAR_M) >> 24);
        rem  = sum - 16'(qest) * 16'(KQ);
        cred = (rem >= 16'(KQ)) ? R_W'(rem - 16'(KQ)) : R_W'(rem);
    end

endmodule

// File: rtl/k2red_arb.sv
// k2red_arb: two-requester arbiter feeding a two-stage K-RED-2 pipeline.
//   clk    sole clock, rising edge
//   rst    asynchronous, active-low reset
//   bus    k2red_arb_if.slave: A/B operand handshakes, result handshake, busy
//   a_cnt, b_cnt (only with K2RED_ARB_CNT_EN) saturating per-requester
//          accepted-transfer counters
// RR_EN = 1 selects round-robin arbitration, 0 selects fixed priority (A wins).
// S1 holds the chosen operand, k2red reduces it, S2 holds the result that
// drives o_*. Ready is offered only to the granted requester.
module k2red_arb
    import kyber_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    k2red_arb_if.slave     bus
`ifdef K2RED_ARB_CNT_EN
    ,
    output logic [15:0]    a_cnt,
    output logic [15:0]    b_cnt
`endif
);

    logic           s1_vld_q, s1_vld_d;
    logic [C_W-1:0] s1_c_q, s1_c_d;
    id_t            s1_id_q, s1_id_d;
    logic           s2_vld_q, s2_vld_d;
    logic [R_W-1:0] s2_cred_q, s2_cred_d;
    id_t            s2_id_q, s2_id_d;
    id_t            last_q, last_d;

    logic           s2_free;
    logic           s1_take;
    logic           gnt_a, gnt_b;
    logic           rdy_a, rdy_b;
    logic           xfer_a, xfer_b;
    logic [R_W-1:0] cred_red;

    k2red u_k2red (
        .c    (s1_c_q),
        .cred (cred_red)
    );

    // Arbitration and ready generation
    always_comb begin
        s2_free = !s2_vld_q || bus.o_rdy;
        s1_take = !s1_vld_q || s2_free;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        if (RR_EN) begin
            if (bus.a_vld && bus.b_vld) begin
                // contention: serve whoever was not served last
                gnt_a = (last_q == ID_B);
                gnt_b = (last_q == ID_A);
            end else begin
                gnt_a = bus.a_vld;
                gnt_b = bus.b_vld;
            end
        end else begin
            gnt_a = bus.a_vld;
            gnt_b = !bus.a_vld && bus.b_vld;
        end
        // rst gates ready directly so nothing is offered while reset is held
        rdy_a  = rst && s1_take && gnt_a;
        rdy_b  = rst && s1_take && gnt_b;
        xfer_a = bus.a_vld && rdy_a;
        xfer_b = bus.b_vld && rdy_b;
    end

    // Pipeline and pointer next state
    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_c_d    = s1_c_q;
        s1_id_d   = s1_id_q;
        s2_vld_d  = s2_vld_q;
        s2_cred_d = s2_cred_q;
        s2_id_d   = s2_id_q;
        last_d    = last_q;

        if (s1_take) begin
            s1_vld_d = xfer_a || xfer_b;
        end
        if (xfer_a) begin
            s1_c_d  = bus.a_c;
            s1_id_d = ID_A;
            last_d  = ID_A;
        end else if (xfer_b) begin
            s1_c_d  = bus.b_c;
            s1_id_d = ID_B;
            last_d  = ID_B;
        end

        if (s2_free) begin
            s2_vld_d = s1_vld_q;
            // data only loads with a real operand so an idle S2 stays quiet
            if (s1_vld_q) begin
                s2_cred_d = cred_red;
                s2_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_c_q    <= '0;
            s1_id_q   <= ID_A;
            s2_vld_q  <= 1'b0;
            s2_cred_q <= '0;
            s2_id_q   <= ID_A;
            // pretend B was served last so A wins the first contention
            last_q    <= ID_B;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_c_q    <= s1_c_d;
            s1_id_q   <= s1_id_d;
            s2_vld_q  <= s2_vld_d;
            s2_cred_q <= s2_cred_d;
            s2_id_q   <= s2_id_d;
            last_q    <= last_d;
        end
    end

    assign bus.a_rdy  = rdy_a;
    assign bus.b_rdy  = rdy_b;
    assign bus.o_vld  = s2_vld_q;
    assign bus.o_cred = s2_cred_q;
    assign bus.o_id   = s2_id_q;
    assign bus.busy   = s1_vld_q || s2_vld_q;

`ifdef K2RED_ARB_CNT_EN
    logic [15:0] a_cnt_q, a_cnt_d;
    logic [15:0] b_cnt_q, b_cnt_d;

    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (xfer_a && (a_cnt_q != 16'hFFFF)) begin
            a_cnt_d = a_cnt_q + 16'd1;
        end
        if (xfer_b && (b_cnt_q != 16'hFFFF)) begin
            b_cnt_d = b_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_cnt = a_cnt_q;
    assign b_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_k2red_arb.sv
// Bench for k2red_arb: dut0 is round-robin, dut1 is fixed priority.
// A queue model per DUT predicts ready, valid, result and busy every cycle;
// directed sequences add hand-computed literal checks.
module tb_k2red_arb;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    k2red_arb_if if0 ();
    k2red_arb_if if1 ();

    logic [15:0] a_cnt0, b_cnt0, a_cnt1, b_cnt1;
`ifndef K2RED_ARB_CNT_EN
    assign a_cnt0 = '0;
    assign b_cnt0 = '0;
    assign a_cnt1 = '0;
    assign b_cnt1 = '0;
`endif

    k2red_arb #(.RR_EN(1'b1)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .bus   (if0.slave)
`ifdef K2RED_ARB_CNT_EN
        ,
        .a_cnt (a_cnt0),
        .b_cnt (b_cnt0)
`endif
    );

    k2red_arb #(.RR_EN(1'b0)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .bus   (if1.slave)
`ifdef K2RED_ARB_CNT_EN
        ,
        .a_cnt (a_cnt1),
        .b_cnt (b_cnt1)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_red(input logic [23:0] c);
        longint unsigned p;
        p = 64'(c) * 64'd169;
        return 12'(p % 64'd3329);
    endfunction

    // ---------------- model: in-flight results in acceptance order ----------
    int unsigned cyc [2];
    int          cnt [2];
    int          hd  [2];
    int          tl  [2];
    bit          ptr [2];          // last served, 1 = B
    logic [11:0] q_cred [2][16];
    bit          q_id   [2][16];
    int unsigned q_acc  [2][16];
    int unsigned m_acnt [2];
    int unsigned m_bcnt [2];

    task automatic model_step(input int d, input bit rr, input logic rv,
                              input logic av, input logic [23:0] ac,
                              input logic bv, input logic [23:0] bc,
                              input logic ordy, input logic ar, input logic br,
                              input logic ov, input logic [11:0] oc, input logic oid,
                              input logic bsy, input logic [15:0] acnt,
                              input logic [15:0] bcnt);
        string tag;
        bit    exp_ov, acc, ga, gb;
        tag = (d == 0) ? "dut0" : "dut1";
        if (!rv) begin
            chk({tag, ".reset_outputs"}, {15'd0, ar, br, ov, oid, bsy, oc}, 32'd0);
            cnt[d] = 0; hd[d] = 0; tl[d] = 0; ptr[d] = 1'b1;
            m_acnt[d] = 0; m_bcnt[d] = 0;
`ifdef K2RED_ARB_CNT_EN
            chk({tag, ".reset_cnt"}, {acnt, bcnt}, 32'd0);
`endif
            return;
        end
        // a result appears two edges after its input transfer
        exp_ov = (cnt[d] > 0) && (cyc[d] - q_acc[d][hd[d]] >= 2);
        chk({tag, ".o_vld"}, ov, exp_ov);
        if (exp_ov) begin
            chk({tag, ".o_cred"}, oc, q_cred[d][hd[d]]);
            chk({tag, ".o_id"}, oid, q_id[d][hd[d]]);
        end
        chk({tag, ".busy"}, bsy, cnt[d] > 0);
        acc = (cnt[d] < 2) || ordy;
        if (rr) begin
            if (av && bv) begin
                ga = ptr[d];
                gb = !ptr[d];
            end else begin
                ga = av;
                gb = bv;
            end
        end else begin
            ga = av;
            gb = !av && bv;
        end
        chk({tag, ".a_rdy"}, ar, acc && ga);
        chk({tag, ".b_rdy"}, br, acc && gb);
`ifdef K2RED_ARB_CNT_EN
        chk({tag, ".a_cnt"}, acnt, m_acnt[d]);
        chk({tag, ".b_cnt"}, bcnt, m_bcnt[d]);
`endif
        if (exp_ov && ordy) begin
            hd[d] = (hd[d] + 1) % 16;
            cnt[d]--;
        end
        if (acc && (ga || gb)) begin
            q_cred[d][tl[d]] = ref_red(ga ? ac : bc);
            q_id[d][tl[d]]   = gb;
            q_acc[d][tl[d]]  = cyc[d];
            tl[d]  = (tl[d] + 1) % 16;
            cnt[d]++;
            ptr[d] = gb;
            if (ga && m_acnt[d] < 65535) m_acnt[d]++;
            if (gb && m_bcnt[d] < 65535) m_bcnt[d]++;
        end
        cyc[d]++;
    endtask

    always @(negedge clk) begin
        model_step(0, 1'b1, rst, if0.a_vld, if0.a_c, if0.b_vld, if0.b_c, if0.o_rdy,
                   if0.a_rdy, if0.b_rdy, if0.o_vld, if0.o_cred, if0.o_id, if0.busy,
                   a_cnt0, b_cnt0);
        model_step(1, 1'b0, rst, if1.a_vld, if1.a_c, if1.b_vld, if1.b_c, if1.o_rdy,
                   if1.a_rdy, if1.b_rdy, if1.o_vld, if1.o_cred, if1.o_id, if1.busy,
                   a_cnt1, b_cnt1);
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [23:0] bvals [5];
        bvals = '{24'hFFFFFF, 24'd3329, 24'd0, 24'h123456, 24'd3328};
        if0.a_vld = 0; if0.a_c = '0; if0.b_vld = 0; if0.b_c = '0; if0.o_rdy = 1;
        if1.a_vld = 0; if1.a_c = '0; if1.b_vld = 0; if1.b_c = '0; if1.o_rdy = 1;

        // reset held with a requester waiting: no ready, outputs idle
        repeat (2) @(posedge clk); #1;
        if0.a_vld = 1; if0.a_c = 24'd1;
        @(negedge clk);
        chk("rst_a_rdy", if0.a_rdy, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_o_vld", if0.o_vld, 0);

        // single A transfer, latency 2, busy for 2 cycles
        @(posedge clk); #1; rst = 1;
        @(negedge clk); chk("t1_a_rdy", if0.a_rdy, 1);
        @(posedge clk); #1; if0.a_vld = 0;
        @(negedge clk); chk("t1_o_vld_early", if0.o_vld, 0); chk("t1_busy1", if0.busy, 1);
        @(negedge clk);
        chk("t1_o_vld", if0.o_vld, 1); chk("t1_o_cred", if0.o_cred, 169);
        chk("t1_o_id", if0.o_id, 0); chk("t1_busy2", if0.busy, 1);
        @(negedge clk); chk("t1_o_vld_after", if0.o_vld, 0); chk("t1_busy_after", if0.busy, 0);

        // round-robin alternation, A first after reset
        do_reset();
        if0.a_vld = 1; if0.a_c = 24'd65536; if0.b_vld = 1; if0.b_c = 24'd100;
        drain(2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_o_vld", if0.o_vld, 1);
            chk("t2_o_cred", if0.o_cred, (k % 2 == 0) ? 32'd1 : 32'd255);
            chk("t2_o_id", if0.o_id, k % 2);
        end
        @(posedge clk); #1; if0.a_vld = 0; if0.b_vld = 0;
        drain(4);

        // stall with a full pipeline, then release
        @(posedge clk); #1;
        if0.o_rdy = 0; if0.a_vld = 1; if0.a_c = 24'd2; if0.b_vld = 1; if0.b_c = 24'd3;
        @(negedge clk); chk("t3_a_rdy", if0.a_rdy, 1);
        @(negedge clk); chk("t3_b_rdy", if0.b_rdy, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_stall_rdy", {if0.a_rdy, if0.b_rdy}, 0);
            chk("t3_stall_cred", if0.o_cred, 338);
            chk("t3_stall_id", if0.o_id, 0);
            chk("t3_stall_vld", if0.o_vld, 1);
        end
        @(posedge clk); #1; if0.o_rdy = 1; if0.a_vld = 0; if0.b_vld = 0;
        @(negedge clk); chk("t3_first", if0.o_cred, 338);
        @(negedge clk); chk("t3_second", if0.o_cred, 507); chk("t3_second_id", if0.o_id, 1);
        @(negedge clk); chk("t3_empty", if0.o_vld, 0);

        // operand boundaries, A only, back to back
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            if0.a_vld = 1; if0.a_c = bvals[i];
            @(negedge clk);
            chk("t4_a_rdy", if0.a_rdy, 1);
            if (i == 2) chk("t4_max_operand", if0.o_cred, 87);
            if (i == 3) chk("t4_q_operand", if0.o_cred, 0);
            @(posedge clk); #1;
        end
        if0.a_vld = 0;
        drain(4);

        // reset with both stages full
        @(posedge clk); #1;
        if0.o_rdy = 0; if0.a_vld = 1; if0.a_c = 24'd10; if0.b_vld = 1; if0.b_c = 24'd11;
        drain(3);
        #2 rst = 0;
        #1;
        chk("t5_rst_o_vld", if0.o_vld, 0); chk("t5_rst_busy", if0.busy, 0);
        chk("t5_rst_cred", if0.o_cred, 0); chk("t5_rst_rdy", {if0.a_rdy, if0.b_rdy}, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1; if0.o_rdy = 1; if0.a_c = 24'd0; if0.b_c = 24'd5;
        @(negedge clk); chk("t5_a_first", if0.a_rdy, 1);
        @(negedge clk);
        @(posedge clk); #1; if0.a_vld = 0; if0.b_vld = 0;
        @(negedge clk);
        chk("t5_o_vld", if0.o_vld, 1); chk("t5_o_cred", if0.o_cred, 0); chk("t5_o_id", if0.o_id, 0);
        @(negedge clk); chk("t5_b_cred", if0.o_cred, 845); chk("t5_b_id", if0.o_id, 1);
        drain(2);

        // fixed priority on dut1
        @(posedge clk); #1;
        if1.a_vld = 1; if1.a_c = 24'd8388608; if1.b_vld = 1; if1.b_c = 24'd7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_a_rdy", if1.a_rdy, 1);
            chk("t6_b_rdy", if1.b_rdy, 0);
            if (k >= 2) begin
                chk("t6_a_cred", if1.o_cred, 128);
                chk("t6_a_id", if1.o_id, 0);
            end
        end
        @(posedge clk); #1; if1.a_vld = 0;
        @(negedge clk); chk("t6_b_rdy_after", if1.b_rdy, 1);
        @(posedge clk); #1; if1.b_vld = 0;
        @(negedge clk); chk("t6_last_a", if1.o_cred, 128);
        @(negedge clk);
        chk("t6_b_vld", if1.o_vld, 1); chk("t6_b_cred", if1.o_cred, 1183);
        chk("t6_b_id", if1.o_id, 1);
        drain(3);

`ifdef K2RED_ARB_CNT_EN
        // transfer counters: A,B,A,B then A alone
        do_reset();
        if0.a_vld = 1; if0.a_c = 24'd1; if0.b_vld = 1; if0.b_c = 24'd2;
        drain(4);
        @(posedge clk); #1; if0.b_vld = 0;
        @(negedge clk);
        @(posedge clk); #1; if0.a_vld = 0;
        @(negedge clk);
        chk("t7_a_cnt", a_cnt0, 3); chk("t7_b_cnt", b_cnt0, 2);
        // long A-only run drives a_cnt into saturation
        @(posedge clk); #1; if0.a_vld = 1;
        repeat (65540) @(negedge clk);
        @(posedge clk); #1; if0.a_vld = 0;
        @(negedge clk);
        chk("t7_a_sat", a_cnt0, 16'hFFFF); chk("t7_b_hold", b_cnt0, 2);
        drain(3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
